pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline stall/flush sequencer at the consumer end of the hazard-detection interface. It takes the load-use/branch `Stall` request plus branch-taken and data-memory-busy events, and drives per-stage enables, flushes and bubble insertion. It also carries the destination-register shadow pipeline (EX/MEM/WB `destReg`, `RegWrite`, `MemRead`) that feeds the hazard detector's comparison inputs. It sits beside the five-stage datapath and owns halt draining.

## Interface
Parameters:
- `CNT_W`, 16, width of the saturating stall/flush statistics counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Stall` in 1: hazard request from the hazard detector (combinational from ID).
- `BranchTaken` in 1: branch/jump resolved taken in ID this cycle.
- `MemBusy` in 1: data memory not ready; the MEM stage must hold.
- `ID_valid` in 1: ID holds a real instruction.
- `ID_destReg` in 4: destination register of the ID instruction.
- `ID_RegWrite`, `ID_MemRead` in 1 each: control bits of the ID instruction.
- `ID_Halt` in 1: ID instruction is HALT.
- `PC_en`, `IFID_en` out 1 each: PC and IF/ID register load enables.
- `IFID_flush` out 1: IF/ID loads a NOP.
- `IDEX_bubble` out 1: ID/EX loads a NOP.
- `IDEX_en`, `EXMEM_en`, `MEMWB_en` out 1 each: stage register enables.
- `destReg`, `MEM_destReg`, `WB_destReg` out 4 each: shadow destinations for EX, MEM and WB.
- `EX_MemRead`, `EX_RegWrite`, `MEM_RegWrite`, `WB_RegWrite` out 1 each: shadow control bits.
- `Halted` out 1: pipeline drained after HALT.
- `stall_cnt`, `flush_cnt` out `CNT_W` each: saturating event counters.

## Operation
- FSM states:
  - RUN (reset state)
  - MEMWAIT
  - DRAIN
  - HALTED
- Priority in RUN (highest first):
  1. **MemBusy:** enter MEMWAIT. All enables are 0 and there is no bubble or flush, so the whole pipe freezes and the shadows hold.
  2. **Stall:** `PC_en` = `IFID_en` = 0, `IDEX_bubble` = 1. EX/MEM/WB advance. The shadow EX slot loads a bubble: `destReg` = 0, `RegWrite` = 0, `MemRead` = 0. `stall_cnt` increments.
  3. **BranchTaken:** `PC_en` = 1, `IFID_flush` = 1, and ID advances normally. `flush_cnt` increments.
  4. **Otherwise:** all enables are 1. The shadow EX loads the ID fields gated by `ID_valid`; an invalid slot loads a bubble.
- `Stall` together with `BranchTaken`: the stall wins. The branch is re-evaluated next cycle, so there is no flush this cycle.
- MEMWAIT:
  - Hold while `MemBusy` = 1.
  - On `MemBusy` = 0, return to RUN and apply the RUN priority (2–4) in that same cycle.
- `ID_Halt` and `ID_valid` seen in RUN with no stall:
  - HALT advances into EX.
  - `PC_en` = `IFID_en` = 0 from then on, and `IFID_flush` = 1 once.
  - Enter DRAIN with a 2-bit drain counter = 3.
- DRAIN:
  - Downstream enables are 1 (still frozen by `MemBusy`).
  - `ID_valid` is ignored and bubbles are inserted.
  - The counter decrements each non-busy cycle. At 0, enter HALTED.
- HALTED:
  - All enables are 0 and `Halted` = 1.
  - Only `rst` exits.
- Shadow pipeline: advances EX→MEM→WB only when the respective enable is 1.
- Counters saturate at all-ones and never wrap.

## Timing
- All outputs reset to 0 except `IFID_flush` = 1 and `IDEX_bubble` = 1 during reset, which clear the front end. State resets to RUN; counters reset to 0.
- Enables, flush and bubble are combinational from the current state and inputs: zero-cycle response to `Stall` in the same cycle.
- Shadow registers update at the rising edge: `destReg` reflects an ID instruction one cycle after it is accepted, `MEM_destReg` two cycles after, `WB_destReg` three cycles after.
- Load-use: the load is in EX (`EX_MemRead` = 1) while the dependent instruction is in ID. The `Stall` cycle inserts one bubble. On the next edge the load moves to MEM, `EX_MemRead` drops to 0, and the dependent instruction proceeds.
- `rst` asserted mid-operation (any state, including MEMWAIT or DRAIN) forces RUN and the reset values at the next edge.
- `Halted` rises exactly 4 non-busy cycles after the HALT cycle in ID.

## Test plan
- **Reset:** hold `rst` for 2 cycles → all shadows 0, counters 0, `Halted` 0; `IFID_flush` = 1 and `IDEX_bubble` = 1 during reset.
- **Load-use:**
  - Stimulus: ID `destReg` = 4'h3 with `ID_MemRead` = 1, accepted; next cycle `Stall` = 1 for 1 cycle.
  - Response: `destReg` = 3 and `EX_MemRead` = 1; during the stall `PC_en` = 0 and `IDEX_bubble` = 1. Next edge: `destReg` = 0, `MEM_destReg` = 3, `stall_cnt` = 1.
- **Branch flush:** `BranchTaken` = 1 for 1 cycle → `IFID_flush` = 1, `PC_en` = 1, `flush_cnt` = 1. With `Stall` = 1 in the same cycle → no flush, `stall_cnt` increments, `flush_cnt` unchanged.
- **MemBusy freeze:**
  - Stimulus: `MemBusy` = 1 for 3 cycles with `Stall` also high.
  - Response: all enables 0 and shadows unchanged for those 3 cycles; `stall_cnt` unchanged. The cycle after release behaves as RUN.
- **Halt drain:** HALT in ID, with `MemBusy` pulsed once during DRAIN → `Halted` = 1 on the fifth cycle instead of the fourth. Then `PC_en` stays 0 indefinitely until `rst`.
- **Counter saturation:** `CNT_W` = 2, `Stall` held for 6 cycles → `stall_cnt` sequence 1, 2, 3, 3, 3, 3.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: drives stage enables, flush and
// bubble, carries the EX/MEM/WB destination shadows and sequences HALT draining.
module pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic             MemBusy,
  input  logic             ID_valid,
  input  logic [3:0]       ID_destReg,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic             ID_Halt,
  output logic             PC_en,
  output logic             IFID_en,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic             IDEX_en,
  output logic             EXMEM_en,
  output logic             MEMWB_en,
  output logic [3:0]       destReg,
  output logic [3:0]       MEM_destReg,
  output logic [3:0]       WB_destReg,
  output logic             EX_MemRead,
  output logic             EX_RegWrite,
  output logic             MEM_RegWrite,
  output logic             WB_RegWrite,
  output logic             Halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MEMWAIT = 2'd1,
    S_DRAIN   = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       drain_q, drain_d;
  logic             stall_inc, flush_inc;

  logic [3:0]       ex_dest_q, mem_dest_q, wb_dest_q;
  logic             ex_rw_q, ex_mr_q, mem_rw_q, wb_rw_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             ex_fill;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // MEMWAIT behaves like RUN once MemBusy drops, so both share one decode path.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    PC_en       = 1'b0;
    IFID_en     = 1'b0;
    IFID_flush  = 1'b0;
    IDEX_bubble = 1'b0;
    IDEX_en     = 1'b0;
    EXMEM_en    = 1'b0;
    MEMWB_en    = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (rst) begin
      IFID_flush  = 1'b1;
      IDEX_bubble = 1'b1;
    end else begin
      case (state_q)
        S_RUN, S_MEMWAIT: begin
          if (MemBusy) begin
            state_d = S_MEMWAIT;
          end else begin
            state_d  = S_RUN;
            IDEX_en  = 1'b1;
            EXMEM_en = 1'b1;
            MEMWB_en = 1'b1;
            if (Stall) begin
              IDEX_bubble = 1'b1;
              stall_inc   = 1'b1;
            end else if (ID_valid && ID_Halt) begin
              IFID_flush = 1'b1;
              state_d    = S_DRAIN;
              drain_d    = 2'd3;
            end else begin
              PC_en   = 1'b1;
              IFID_en = 1'b1;
              if (BranchTaken) begin
                IFID_flush = 1'b1;
                flush_inc  = 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (!MemBusy) begin
            IDEX_en     = 1'b1;
            EXMEM_en    = 1'b1;
            MEMWB_en    = 1'b1;
            IDEX_bubble = 1'b1;
            drain_d     = drain_q - 2'd1;
            if (drain_q <= 2'd1) begin
              state_d = S_HALTED;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ex_fill = ID_valid && !IDEX_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      drain_q     <= 2'd0;
      ex_dest_q   <= 4'd0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      mem_dest_q  <= 4'd0;
      mem_rw_q    <= 1'b0;
      wb_dest_q   <= 4'd0;
      wb_rw_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      // EX shadow: an invalid or bubbled slot carries no destination
      if (IDEX_en) begin
        ex_dest_q <= ex_fill ? ID_destReg : 4'd0;
        ex_rw_q   <= ex_fill && ID_RegWrite;
        ex_mr_q   <= ex_fill && ID_MemRead;
      end
      // MEM shadow
      if (EXMEM_en) begin
        mem_dest_q <= ex_dest_q;
        mem_rw_q   <= ex_rw_q;
      end
      // WB shadow
      if (MEMWB_en) begin
        wb_dest_q <= mem_dest_q;
        wb_rw_q   <= mem_rw_q;
      end
      if (stall_inc) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush_inc) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign destReg      = ex_dest_q;
  assign EX_RegWrite  = ex_rw_q;
  assign EX_MemRead   = ex_mr_q;
  assign MEM_destReg  = mem_dest_q;
  assign MEM_RegWrite = mem_rw_q;
  assign WB_destReg   = wb_dest_q;
  assign WB_RegWrite  = wb_rw_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign Halted       = (state_q == S_HALTED) && !rst;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, every cycle compared
// against a slot-list model of the pipeline; a second instance uses 2-bit counters.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, Stall, BranchTaken, MemBusy, ID_valid, ID_RegWrite, ID_MemRead, ID_Halt;
  logic [3:0] ID_destReg;

  logic        PC_en, IFID_en, IFID_flush, IDEX_bubble, IDEX_en, EXMEM_en, MEMWB_en;
  logic [3:0]  destReg, MEM_destReg, WB_destReg;
  logic        EX_MemRead, EX_RegWrite, MEM_RegWrite, WB_RegWrite, Halted;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_PC_en, s_IFID_en, s_IFID_flush, s_IDEX_bubble, s_IDEX_en, s_EXMEM_en, s_MEMWB_en;
  logic [3:0]  s_destReg, s_MEM_destReg, s_WB_destReg;
  logic        s_EX_MemRead, s_EX_RegWrite, s_MEM_RegWrite, s_WB_RegWrite, s_Halted;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  pipe_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .BranchTaken(BranchTaken), .MemBusy(MemBusy),
    .ID_valid(ID_valid), .ID_destReg(ID_destReg), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_Halt(ID_Halt),
    .PC_en(PC_en), .IFID_en(IFID_en), .IFID_flush(IFID_flush), .IDEX_bubble(IDEX_bubble),
    .IDEX_en(IDEX_en), .EXMEM_en(EXMEM_en), .MEMWB_en(MEMWB_en),
    .destReg(destReg), .MEM_destReg(MEM_destReg), .WB_destReg(WB_destReg),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .MEM_RegWrite(MEM_RegWrite),
    .WB_RegWrite(WB_RegWrite), .Halted(Halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .Stall(Stall), .BranchTaken(BranchTaken), .MemBusy(MemBusy),
    .ID_valid(ID_valid), .ID_destReg(ID_destReg), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_Halt(ID_Halt),
    .PC_en(s_PC_en), .IFID_en(s_IFID_en), .IFID_flush(s_IFID_flush), .IDEX_bubble(s_IDEX_bubble),
    .IDEX_en(s_IDEX_en), .EXMEM_en(s_EXMEM_en), .MEMWB_en(s_MEMWB_en),
    .destReg(s_destReg), .MEM_destReg(s_MEM_destReg), .WB_destReg(s_WB_destReg),
    .EX_MemRead(s_EX_MemRead), .EX_RegWrite(s_EX_RegWrite), .MEM_RegWrite(s_MEM_RegWrite),
    .WB_RegWrite(s_WB_RegWrite), .Halted(s_Halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: slot[0]=EX, slot[1]=MEM, slot[2]=WB; halt_age counts non-busy cycles since HALT.
  logic [3:0] m_dest[3];
  logic       m_rw[3];
  logic       m_mr[3];
  bit         m_halt;
  int         m_age;
  int         m_sc, m_fc, m_sc2, m_fc2;

  bit e_pc, e_ifen, e_fl, e_bub, e_idex, e_exmem, e_memwb, e_halted;
  bit ev_stall, ev_flush, ev_halt;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_dest[i] = 4'd0;
      m_rw[i]   = 1'b0;
      m_mr[i]   = 1'b0;
    end
    m_halt = 0; m_age = 0;
    m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
  endtask

  task automatic model_comb();
    e_pc = 0; e_ifen = 0; e_fl = 0; e_bub = 0; e_idex = 0; e_exmem = 0; e_memwb = 0;
    ev_stall = 0; ev_flush = 0; ev_halt = 0;
    if (rst) begin
      e_fl = 1; e_bub = 1;
    end else if (m_halt) begin
      if (m_age < 4 && !MemBusy) begin
        e_idex = 1; e_exmem = 1; e_memwb = 1; e_bub = 1;
      end
    end else if (!MemBusy) begin
      e_idex = 1; e_exmem = 1; e_memwb = 1;
      if (Stall) begin
        e_bub = 1; ev_stall = 1;
      end else if (ID_valid && ID_Halt) begin
        e_fl = 1; ev_halt = 1;
      end else begin
        e_pc = 1; e_ifen = 1;
        if (BranchTaken) begin
          e_fl = 1; ev_flush = 1;
        end
      end
    end
    e_halted = m_halt && (m_age >= 4) && !rst;
  endtask

  task automatic model_step();
    bit fill;
    if (rst) begin
      model_reset();
      return;
    end
    if (e_idex) begin
      fill = ID_valid && !e_bub;
      m_dest[2] = m_dest[1]; m_rw[2] = m_rw[1]; m_mr[2] = m_mr[1];
      m_dest[1] = m_dest[0]; m_rw[1] = m_rw[0]; m_mr[1] = m_mr[0];
      m_dest[0] = fill ? ID_destReg : 4'd0;
      m_rw[0]   = fill && ID_RegWrite;
      m_mr[0]   = fill && ID_MemRead;
    end
    if (ev_stall) begin
      m_sc  = (m_sc < 65535) ? m_sc + 1 : m_sc;
      m_sc2 = (m_sc2 < 3) ? m_sc2 + 1 : m_sc2;
    end
    if (ev_flush) begin
      m_fc  = (m_fc < 65535) ? m_fc + 1 : m_fc;
      m_fc2 = (m_fc2 < 3) ? m_fc2 + 1 : m_fc2;
    end
    if (ev_halt) begin
      m_halt = 1; m_age = 1;
    end else if (m_halt && m_age < 4 && !MemBusy) begin
      m_age++;
    end
  endtask

  task automatic check_all();
    chk("PC_en",        32'(PC_en),        32'(e_pc));
    chk("IFID_en",      32'(IFID_en),      32'(e_ifen));
    chk("IFID_flush",   32'(IFID_flush),   32'(e_fl));
    chk("IDEX_bubble",  32'(IDEX_bubble),  32'(e_bub));
    chk("IDEX_en",      32'(IDEX_en),      32'(e_idex));
    chk("EXMEM_en",     32'(EXMEM_en),     32'(e_exmem));
    chk("MEMWB_en",     32'(MEMWB_en),     32'(e_memwb));
    chk("destReg",      32'(destReg),      32'(m_dest[0]));
    chk("EX_RegWrite",  32'(EX_RegWrite),  32'(m_rw[0]));
    chk("EX_MemRead",   32'(EX_MemRead),   32'(m_mr[0]));
    chk("MEM_destReg",  32'(MEM_destReg),  32'(m_dest[1]));
    chk("MEM_RegWrite", 32'(MEM_RegWrite), 32'(m_rw[1]));
    chk("WB_destReg",   32'(WB_destReg),   32'(m_dest[2]));
    chk("WB_RegWrite",  32'(WB_RegWrite),  32'(m_rw[2]));
    chk("Halted",       32'(Halted),       32'(e_halted));
    chk("stall_cnt",    32'(stall_cnt),    32'(m_sc));
    chk("flush_cnt",    32'(flush_cnt),    32'(m_fc));
    chk("sat_stall",    32'(s_stall_cnt),  32'(m_sc2));
    chk("sat_flush",    32'(s_flush_cnt),  32'(m_fc2));
  endtask

  // One clock: drive, check at the falling edge, advance the model at the rising edge.
  task automatic cyc(input logic r, input logic st, input logic br, input logic mb,
                     input logic v, input logic [3:0] d, input logic rw, input logic mr,
                     input logic hl);
    rst = r; Stall = st; BranchTaken = br; MemBusy = mb;
    ID_valid = v; ID_destReg = d; ID_RegWrite = rw; ID_MemRead = mr; ID_Halt = hl;
    @(negedge clk);
    model_comb();
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input logic mb);
    cyc(1'b0, 1'b0, 1'b0, mb, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  int exp_sat[6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    rst = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; MemBusy = 1'b0;
    ID_valid = 1'b0; ID_destReg = 4'd0; ID_RegWrite = 1'b0; ID_MemRead = 1'b0; ID_Halt = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // reset held two cycles
    cyc(1, 0, 0, 0, 1, 4'h7, 1, 0, 0);
    cyc(1, 1, 1, 0, 1, 4'h7, 1, 0, 0);

    // load-use: load to r3 accepted, then one stall cycle
    cyc(0, 0, 0, 0, 1, 4'h3, 1, 1, 0);
    chk("lu_dest", 32'(destReg), 32'd3);
    chk("lu_mr", 32'(EX_MemRead), 32'd1);
    cyc(0, 1, 0, 0, 1, 4'h5, 1, 0, 0);
    chk("lu_bubble_dest", 32'(destReg), 32'd0);
    chk("lu_mem_dest", 32'(MEM_destReg), 32'd3);
    chk("lu_mr_drop", 32'(EX_MemRead), 32'd0);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // branch flush, then branch together with stall
    cyc(0, 0, 1, 0, 1, 4'h5, 1, 0, 0);
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    cyc(0, 1, 1, 0, 1, 4'h6, 1, 0, 0);
    chk("br_stall_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_stall_stall_cnt", 32'(stall_cnt), 32'd2);

    // MemBusy freeze with Stall high
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 1, 4'h9, 1, 1, 0);
    chk("busy_stall_cnt", 32'(stall_cnt), 32'd2);
    chk("busy_dest_hold", 32'(destReg), 32'd0);
    cyc(0, 0, 0, 0, 1, 4'hA, 1, 0, 0);
    chk("busy_release_dest", 32'(destReg), 32'hA);

    // halt drain with a MemBusy pulse
    cyc(1, 0, 0, 0, 0, 4'd0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 4'hC, 0, 0, 1);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    chk("halt_not_yet", 32'(Halted), 32'd0);
    idle(1'b0);
    chk("halt_rise", 32'(Halted), 32'd1);
    for (int i = 0; i < 6; i++)
      cyc(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1,
          4'($urandom), 1, 1, 1'($urandom_range(1)));
    chk("halt_pc_stuck", 32'(PC_en), 32'd0);
    chk("halt_stays", 32'(Halted), 32'd1);

    // counter saturation on the 2-bit instance
    cyc(1, 0, 0, 0, 0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, 0, 1, 4'h2, 1, 0, 0);
      chk("sat_seq", 32'(s_stall_cnt), 32'(exp_sat[i]));
    end

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      cyc(($urandom_range(149) == 0),
          ($urandom_range(4) == 0),
          ($urandom_range(5) == 0),
          ($urandom_range(5) == 0),
          ($urandom_range(3) != 0),
          4'($urandom),
          1'($urandom_range(1)),
          1'($urandom_range(1)),
          ($urandom_range(39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
